bus_switch_n: RTL and testbench

- Parametrised successor to the two-way address-decoded bus switch.
- Routes one inbound addr/data stream to NUM_PORTS outbound ports using valid/ready handshakes on every side.
- Each outbound port has its own DEPTH-entry FIFO, so a stalled port does not hold beats already queued for other ports.
- Sits between a single bus master and several peripheral regions; optional drop mode with a saturating drop counter.

---
 rtl/bus_switch_n.sv | 148 ++++++++++++++
 tb/tb_bus_switch_n.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_switch_n.sv
// bus_switch_n
// ------------
// Address-decoded 1-to-N bus switch. One inbound addr/data stream is routed
// to NUM_PORTS outbound ports. Each outbound port has its own DEPTH-entry
// FIFO, so a stalled consumer only blocks beats aimed at its own port.
//
// Handshake semantics (all sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holds valid and its payload
// stable until the transfer happens; ready may depend combinationally on the
// payload (in_ready depends on in_addr).
//
// Ports:
//   clk        in   1             clock, rising edge
//   resetn     in   1             synchronous active-low reset
//   in_valid   in   1             inbound beat valid
//   in_ready   out  1             switch can take the inbound beat
//   in_addr    in   AW            inbound address (forwarded unmodified)
//   in_data    in   DW            inbound data
//   out_valid  out  NUM_PORTS     per-port head-of-FIFO valid
//   out_ready  in   NUM_PORTS     per-port consumer ready
//   out_addr   out  NUM_PORTS*AW  port p at [p*AW +: AW]
//   out_data   out  NUM_PORTS*DW  port p at [p*DW +: DW]
//   drop_cnt   out  16            discarded beats, saturating at 16'hFFFF
//
// Region decode: the top clog2(NUM_PORTS) address bits select the port.
// DROP_ON_FULL=0 backpressures on a full target FIFO; DROP_ON_FULL=1 always
// accepts and discards beats aimed at a full FIFO.

module bus_switch_n #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int NUM_PORTS    = 4,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AW-1:0]           in_addr,
  input  logic [DW-1:0]           in_data,
  output logic [NUM_PORTS-1:0]    out_valid,
  input  logic [NUM_PORTS-1:0]    out_ready,
  output logic [NUM_PORTS*AW-1:0] out_addr,
  output logic [NUM_PORTS*DW-1:0] out_data,
  output logic [15:0]             drop_cnt
);

  localparam int PSEL_W = $clog2(NUM_PORTS);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0] wr_ptr_d [NUM_PORTS];
  logic [PTR_W-1:0] rd_ptr_q [NUM_PORTS];
  logic [PTR_W-1:0] rd_ptr_d [NUM_PORTS];

  logic [AW-1:0] addr_mem_q [NUM_PORTS][DEPTH];
  logic [AW-1:0] addr_mem_d [NUM_PORTS][DEPTH];
  logic [DW-1:0] data_mem_q [NUM_PORTS][DEPTH];
  logic [DW-1:0] data_mem_d [NUM_PORTS][DEPTH];

  logic [15:0] drop_cnt_q;
  logic [15:0] drop_cnt_d;

  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] pop;
  logic [PSEL_W-1:0]    sel;
  logic                 push;
  logic                 drop;

  // FIFO status and inbound accept decisions. Full is taken from the
  // registered pointers, so a same-cycle pop never frees room for a push.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
      full[p]  = (wr_ptr_q[p][PTR_W-1] != rd_ptr_q[p][PTR_W-1]) &&
                 (wr_ptr_q[p][IDX_W-1:0] == rd_ptr_q[p][IDX_W-1:0]);
      pop[p]   = !empty[p] && out_ready[p];
    end
    sel      = in_addr[AW-1 -: PSEL_W];
    in_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full[sel];
    push     = in_valid && in_ready && !full[sel];
    drop     = in_valid && in_ready && full[sel];
  end

  // Next-state: pointer advance, storage write, drop counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    drop_cnt_d = drop_cnt_q;

    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pop[p]) begin
        rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
      end
    end

    if (push) begin
      addr_mem_d[sel][wr_ptr_q[sel][IDX_W-1:0]] = in_addr;
      data_mem_d[sel][wr_ptr_q[sel][IDX_W-1:0]] = in_data;
      wr_ptr_d[sel] = wr_ptr_q[sel] + PTR_W'(1);
    end

    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Outputs come straight from registered storage: the head entry is
  // addressed by the read pointer and cannot change while it is not popped.
  always_comb begin
    out_valid = ~empty;
    out_addr  = '0;
    out_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      out_addr[p*AW +: AW] = addr_mem_q[p][rd_ptr_q[p][IDX_W-1:0]];
      out_data[p*DW +: DW] = data_mem_q[p][rd_ptr_q[p][IDX_W-1:0]];
    end
    drop_cnt = drop_cnt_q;
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          addr_mem_q[p][e] <= '0;
          data_mem_q[p][e] <= '0;
        end
      end
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_switch_n.sv
// tb_bus_switch_n
// ---------------
// Two switch instances: dut_a backpressures on full (DROP_ON_FULL=0),
// dut_b discards on full (DROP_ON_FULL=1). Driver tasks issue directed beats
// and push the expected {addr,data} per port; a negedge monitor pops and
// compares every beat the switch hands out.

module tb_bus_switch_n;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NP = 4;
  localparam int W  = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              a_in_valid, b_in_valid;
  logic              a_in_ready, b_in_ready;
  logic [AW-1:0]     a_in_addr, b_in_addr;
  logic [DW-1:0]     a_in_data, b_in_data;
  logic [NP-1:0]     a_out_valid, b_out_valid;
  logic [NP-1:0]     a_out_ready, b_out_ready;
  logic [NP*AW-1:0]  a_out_addr, b_out_addr;
  logic [NP*DW-1:0]  a_out_data, b_out_data;
  logic [15:0]       a_drop_cnt, b_drop_cnt;

  bus_switch_n #(.AW(AW), .DW(DW), .NUM_PORTS(NP), .DEPTH(4), .DROP_ON_FULL(0)) dut_a (
    .clk(clk), .resetn(resetn),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr), .out_data(a_out_data),
    .drop_cnt(a_drop_cnt)
  );

  bus_switch_n #(.AW(AW), .DW(DW), .NUM_PORTS(NP), .DEPTH(4), .DROP_ON_FULL(1)) dut_b (
    .clk(clk), .resetn(resetn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a_q [NP][$];
  logic [W-1:0] exp_b_q [NP][$];
  int tests_run = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += exp_a_q[p].size() + exp_b_q[p].size();
    return n;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      for (int p = 0; p < NP; p++) begin
        if (a_out_valid[p] && a_out_ready[p]) begin
          if (exp_a_q[p].size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL a_unexpected_beat: port %0d got %h expected none", p,
                     {a_out_addr[p*AW +: AW], a_out_data[p*DW +: DW]});
          end else begin
            check($sformatf("a_beat_p%0d", p), 32'({a_out_addr[p*AW +: AW], a_out_data[p*DW +: DW]}),
                  32'(exp_a_q[p].pop_front()));
          end
        end
        if (b_out_valid[p] && b_out_ready[p]) begin
          if (exp_b_q[p].size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL b_unexpected_beat: port %0d got %h expected none", p,
                     {b_out_addr[p*AW +: AW], b_out_data[p*DW +: DW]});
          end else begin
            check($sformatf("b_beat_p%0d", p), 32'({b_out_addr[p*AW +: AW], b_out_data[p*DW +: DW]}),
                  32'(exp_b_q[p].pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one beat and holds it until accepted (bounded). 'stored' says
  // whether the hand-computed model expects the beat to land in a FIFO.
  task automatic send(input bit to_b, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input bit stored);
    logic [1:0] p;
    int waited;
    bit ok;
    p = addr[AW-1 -: 2];
    waited = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    if (to_b) begin b_in_valid = 1'b1; b_in_addr = addr; b_in_data = data; end
    else      begin a_in_valid = 1'b1; a_in_addr = addr; a_in_data = data; end
    while (!ok && waited < 64) begin
      @(negedge clk);
      if (to_b ? b_in_ready : a_in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok && stored) begin
      if (to_b) exp_b_q[p].push_back({addr, data});
      else      exp_a_q[p].push_back({addr, data});
    end
    @(posedge clk); #1;
    if (to_b) b_in_valid = 1'b0;
    else      a_in_valid = 1'b0;
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: addr %h never accepted, expected accept within 64 cycles", addr);
    end else if (stored) begin
      check("valid_after_accept", 32'(to_b ? b_out_valid[p] : a_out_valid[p]), 32'd1);
    end
  endtask

  // Presents a beat on dut_a for one cycle and requires in_ready low.
  task automatic probe_not_ready(input logic [AW-1:0] addr);
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_in_addr  = addr;
    a_in_data  = 16'hDEAD;
    @(negedge clk);
    check("in_ready_low_when_full", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    check(name, 32'(pending()), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    a_in_valid = 1'b0; a_in_addr = '0; a_in_data = '0; a_out_ready = '0;
    b_in_valid = 1'b0; b_in_addr = '0; b_in_data = '0; b_out_ready = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_addr", a_out_addr, 32'd0);
    check("rst_out_data_lo", a_out_data[31:0], 32'd0);
    check("rst_out_data_hi", a_out_data[63:32], 32'd0);
    check("rst_drop_cnt", 32'(b_drop_cnt), 32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);

    // Decode: one beat per region, all consumers ready
    a_out_ready = 4'b1111;
    send(1'b0, 8'h10, 16'hAAAA, 1'b1);
    send(1'b0, 8'h50, 16'hBBBB, 1'b1);
    send(1'b0, 8'h90, 16'hCCCC, 1'b1);
    send(1'b0, 8'hF0, 16'hDDDD, 1'b1);
    wait_drain("drain_decode");
    check("decode_drop_cnt", 32'(a_drop_cnt), 32'd0);

    // Backpressure on a stalled port; other ports keep flowing
    a_out_ready = 4'b1101;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h40 + 8'(i), 16'h1000 + 16'(i), 1'b1);
    probe_not_ready(8'h44);
    send(1'b0, 8'h00, 16'h2000, 1'b1);
    fork
      send(1'b0, 8'h44, 16'h1004, 1'b1);
      begin @(posedge clk); #1 a_out_ready[1] = 1'b1; end
    join
    wait_drain("drain_backpressure");

    // Full refuses a push even with a same-cycle pop; then push+pop keeps 3
    a_out_ready = 4'b1011;
    for (int i = 0; i < 4; i++) send(1'b0, 8'h80 + 8'(i), 16'h3000 + 16'(i), 1'b1);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_addr = 8'h84; a_in_data = 16'h3004;
    a_out_ready[2] = 1'b1;
    @(negedge clk);
    check("full_refuses_push", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_pop", 32'(a_in_ready), 32'd1);
    exp_a_q[2].push_back({8'h84, 16'h3004});
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready[2] = 1'b0;
    send(1'b0, 8'h85, 16'h3005, 1'b1);   // occupancy 3 -> 4
    probe_not_ready(8'h86);              // occupancy is now 4
    a_out_ready[2] = 1'b1;
    wait_drain("drain_push_pop");

    // Pointer wrap-around with a toggling consumer
    a_out_ready = 4'b1110;
    fork
      for (int i = 0; i < 20; i++) send(1'b0, 8'(i), 16'h5000 + 16'(i), 1'b1);
      begin
        for (int c = 0; c < 120; c++) begin
          @(posedge clk); #1 a_out_ready[0] = ((c % 2) == 0);
        end
        a_out_ready[0] = 1'b1;
      end
    join
    wait_drain("drain_wrap");

    // Drop mode: 4 stored, 3 discarded, in_ready stays high
    b_out_ready = 4'b0111;
    for (int i = 0; i < 7; i++) send(1'b1, 8'hC0 + 8'(i), 16'h6000 + 16'(i), i < 4);
    check("drop_cnt_3", 32'(b_drop_cnt), 32'd3);
    check("drop_in_ready", 32'(b_in_ready), 32'd1);

    // Drive the counter up to saturation
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_addr = 8'hC7; b_in_data = 16'h6007;
    repeat (65531) @(posedge clk);
    #1 check("drop_cnt_fffe", 32'(b_drop_cnt), 32'h0000FFFE);
    @(posedge clk);
    #1 check("drop_cnt_ffff", 32'(b_drop_cnt), 32'h0000FFFF);
    repeat (2) @(posedge clk);
    #1 check("drop_cnt_saturated", 32'(b_drop_cnt), 32'h0000FFFF);
    b_in_valid = 1'b0;
    b_out_ready = 4'b1111;
    wait_drain("drain_drop");
    check("a_drop_cnt_zero", 32'(a_drop_cnt), 32'd0);

    // Reset with beats queued on port 1
    a_out_ready = 4'b1101;
    for (int i = 0; i < 3; i++) send(1'b0, 8'h60 + 8'(i), 16'h7000 + 16'(i), 1'b1);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    exp_a_q[1].delete();
    check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_out_addr", a_out_addr, 32'd0);
    check("mid_rst_a_drop_cnt", 32'(a_drop_cnt), 32'd0);
    check("mid_rst_b_drop_cnt", 32'(b_drop_cnt), 32'd0);
    a_out_ready = 4'b1111;
    send(1'b0, 8'h68, 16'h7777, 1'b1);
    wait_drain("drain_post_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
